// File: rtl/garland_pkg.sv
// Shared constants for the garland pattern engine: mode encodings,
// handoff/blink phase encodings and a width helper for the counters.
package garland_pkg;

  localparam logic [1:0] MODE_CHASE   = 2'd0;
  localparam logic [1:0] MODE_HANDOFF = 2'd1;
  localparam logic [1:0] MODE_BLINK   = 2'd2;
  localparam logic [1:0] MODE_OFF     = 2'd3;

  localparam logic PH_RED   = 1'b0;
  localparam logic PH_GREEN = 1'b1;

  // Bits needed to hold 0..value-1, never less than one bit.
  function automatic int minWidth(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/garland_tick.sv
// Pattern-step prescaler: emits a one-cycle tick every TICK_DIV enabled
// clocks. clr restarts the count and suppresses the tick on that edge.
module garland_tick
  import garland_pkg::*;
#(
  parameter int TICK_DIV = 25
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = minWidth(TICK_DIV);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_atMax;

  assign w_atMax = (r_cnt == CNT_MAX);
  assign tick    = en && !clr && w_atMax;

  // Count enabled cycles, wrapping to zero on the tick cycle; a clear wins over counting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (en) begin
      if (w_atMax) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/garland_rejim_n.sv
// Garland pattern engine: drives a red and a green chain of N lamps in
// CHASE, HANDOFF, BLINK or OFF mode, stepping once per prescaler tick.
// All outputs are registered; a mode change restarts the pattern.
module garland_rejim_n
  import garland_pkg::*;
#(
  parameter int N         = 4,
  parameter int TICK_DIV  = 25,
  parameter int GREEN_OFS = 0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   mode,
  input  logic         en,
  output logic [N-1:0] red,
  output logic [N-1:0] green,
  output logic         tick_out,
  output logic         r_task,
  output logic         g_task
);

  if (N < 2) begin : gBadN
    $fatal(1, "garland_rejim_n: N must be at least 2");
  end
  if (TICK_DIV < 1) begin : gBadDiv
    $fatal(1, "garland_rejim_n: TICK_DIV must be at least 1");
  end
  if (GREEN_OFS < 0 || GREEN_OFS >= N) begin : gBadOfs
    $fatal(1, "garland_rejim_n: GREEN_OFS must be in 0..N-1");
  end

  localparam int POS_W  = minWidth(N);
  localparam int POS_W1 = POS_W + 1;

  localparam logic [POS_W-1:0] LAST_POS = POS_W'(N - 1);
  localparam logic [POS_W:0]   N_EXT    = POS_W1'(N);
  localparam logic [POS_W:0]   OFS_EXT  = POS_W1'(GREEN_OFS);
  localparam logic [N-1:0]     ONE      = {{(N-1){1'b0}}, 1'b1};
  localparam logic [N-1:0]     ALL_ON   = '1;

  logic [1:0]       r_modeQ;
  logic [POS_W-1:0] r_pos;
  logic             r_phase;
  logic [N-1:0]     r_red;
  logic [N-1:0]     r_green;
  logic             r_rTask;
  logic             r_gTask;
  logic             r_tickOut;

  logic             w_modeChange;
  logic             w_tick;
  logic             w_lastPos;
  logic [POS_W-1:0] w_posWrap;
  logic [POS_W:0]   w_ofsSum;
  logic [POS_W-1:0] w_ofsIdx;

  logic [N-1:0]     w_redNext;
  logic [N-1:0]     w_greenNext;
  logic             w_rTaskNext;
  logic             w_gTaskNext;
  logic [POS_W-1:0] w_posNext;
  logic             w_phaseNext;

  assign w_modeChange = (mode != r_modeQ);
  assign w_lastPos    = (r_pos == LAST_POS);
  assign w_posWrap    = w_lastPos ? '0 : r_pos + 1'b1;

  // The green lamp index in CHASE is pos+GREEN_OFS folded back into 0..N-1.
  assign w_ofsSum = {1'b0, r_pos} + OFS_EXT;
  assign w_ofsIdx = (w_ofsSum >= N_EXT) ? POS_W'(w_ofsSum - N_EXT) : POS_W'(w_ofsSum);

  garland_tick #(
    .TICK_DIV(TICK_DIV)
  ) uTick (
    .clk (clk),
    .rst (rst),
    .en  (en),
    .clr (w_modeChange),
    .tick(w_tick)
  );

  // Compute the lamp state and position/phase that one pattern step would produce.
  always_comb begin
    w_redNext   = '0;
    w_greenNext = '0;
    w_rTaskNext = 1'b0;
    w_gTaskNext = 1'b0;
    w_posNext   = r_pos;
    w_phaseNext = r_phase;
    case (r_modeQ)
      MODE_CHASE: begin
        w_redNext   = ONE << r_pos;
        w_greenNext = ONE << w_ofsIdx;
        w_posNext   = w_posWrap;
      end
      MODE_HANDOFF: begin
        w_posNext = w_posWrap;
        if (r_phase == PH_RED) begin
          w_redNext   = ONE << (LAST_POS - r_pos);
          w_rTaskNext = 1'b1;
          if (w_lastPos) begin
            w_phaseNext = PH_GREEN;
          end
        end else begin
          w_greenNext = ONE << r_pos;
          w_gTaskNext = 1'b1;
          if (w_lastPos) begin
            w_phaseNext = PH_RED;
          end
        end
      end
      MODE_BLINK: begin
        w_phaseNext = ~r_phase;
        if (r_phase == PH_RED) begin
          w_redNext = ALL_ON;
        end else begin
          w_greenNext = ALL_ON;
        end
      end
      default: begin
        w_redNext   = '0;
        w_greenNext = '0;
      end
    endcase
  end

  // Register mode, pattern position and lamps: restart on mode change, blank in OFF, step on tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_modeQ <= MODE_CHASE;
      r_pos   <= '0;
      r_phase <= PH_RED;
      r_red   <= '0;
      r_green <= '0;
      r_rTask <= 1'b0;
      r_gTask <= 1'b0;
    end else if (w_modeChange) begin
      r_modeQ <= mode;
      r_pos   <= '0;
      r_phase <= PH_RED;
      r_red   <= '0;
      r_green <= '0;
      r_rTask <= 1'b0;
      r_gTask <= 1'b0;
    end else if (r_modeQ == MODE_OFF) begin
      r_red   <= '0;
      r_green <= '0;
      r_rTask <= 1'b0;
      r_gTask <= 1'b0;
    end else if (w_tick) begin
      r_pos   <= w_posNext;
      r_phase <= w_phaseNext;
      r_red   <= w_redNext;
      r_green <= w_greenNext;
      r_rTask <= w_rTaskNext;
      r_gTask <= w_gTaskNext;
    end
  end

  // Delay the prescaler tick by one edge so it lines up with the lamp update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tickOut <= 1'b0;
    end else begin
      r_tickOut <= w_tick;
    end
  end

  assign red      = r_red;
  assign green    = r_green;
  assign r_task   = r_rTask;
  assign g_task   = r_gTask;
  assign tick_out = r_tickOut;

endmodule

// File: tb/tb_garland_rejim_n.sv
// Directed bench for garland_rejim_n: a table of {mode, en, cycles, expected
// lamps} rows for the default instance, plus hand sequences for async reset,
// a GREEN_OFS=2 instance and a TICK_DIV=1 instance.
module tb_garland_rejim_n;

  typedef struct {
    logic [1:0] mode;
    logic       en;
    int         cycles;
    logic [3:0] expRed;
    logic [3:0] expGreen;
    logic       expRTask;
    logic       expGTask;
    logic       expTick;
  } vec_t;

  logic       clk;
  logic       rst;
  logic [1:0] mode, mode1, mode2;
  logic       en, en1, en2;

  logic [3:0] red0, green0, red1, green1, red2, green2;
  logic       tick0, rTask0, gTask0;
  logic       tick1, rTask1, gTask1;
  logic       tick2, rTask2, gTask2;

  int compared;
  int mismatched;

  vec_t vecQ[$];

  garland_rejim_n #(.N(4), .TICK_DIV(25), .GREEN_OFS(0)) dut0 (
    .clk(clk), .rst(rst), .mode(mode), .en(en),
    .red(red0), .green(green0), .tick_out(tick0), .r_task(rTask0), .g_task(gTask0)
  );

  garland_rejim_n #(.N(4), .TICK_DIV(25), .GREEN_OFS(2)) dut1 (
    .clk(clk), .rst(rst), .mode(mode1), .en(en1),
    .red(red1), .green(green1), .tick_out(tick1), .r_task(rTask1), .g_task(gTask1)
  );

  garland_rejim_n #(.N(4), .TICK_DIV(1), .GREEN_OFS(0)) dut2 (
    .clk(clk), .rst(rst), .mode(mode2), .en(en2),
    .red(red2), .green(green2), .tick_out(tick2), .r_task(rTask2), .g_task(gTask2)
  );

  // Free-running 10-unit clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance n rising edges and settle 1 unit past the last one.
  task automatic stepClk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [1:0] m, input logic e, input int n);
    mode = m;
    en   = e;
    stepClk(n);
  endtask

  task automatic checkOutput(input string name, input logic [10:0] actual, input logic [10:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got red/green/r/g/tick=%b expected %b", name, actual, expected);
    end
  endtask

  function automatic logic [10:0] packExp(input logic [3:0] r, input logic [3:0] g,
                                          input logic rt, input logic gt, input logic tk);
    return {r, g, rt, gt, tk};
  endfunction

  initial begin
    logic [3:0] seq2[5];

    compared   = 0;
    mismatched = 0;
    rst   = 1'b1;
    mode  = 2'd0; en  = 1'b1;
    mode1 = 2'd0; en1 = 1'b1;
    mode2 = 2'd0; en2 = 1'b0;
    seq2  = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};

    // CHASE from reset
    vecQ.push_back('{2'd0, 1'b1, 24,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd0, 1'b1, 1,   4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1});
    vecQ.push_back('{2'd0, 1'b1, 1,   4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd0, 1'b1, 24,  4'b0010, 4'b0010, 1'b0, 1'b0, 1'b1});
    vecQ.push_back('{2'd0, 1'b1, 25,  4'b0100, 4'b0100, 1'b0, 1'b0, 1'b1});
    vecQ.push_back('{2'd0, 1'b1, 25,  4'b1000, 4'b1000, 1'b0, 1'b0, 1'b1});
    vecQ.push_back('{2'd0, 1'b1, 25,  4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1});
    // HANDOFF: red sweeps down, then green sweeps up
    vecQ.push_back('{2'd1, 1'b1, 1,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd1, 1'b1, 25,  4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1});
    vecQ.push_back('{2'd1, 1'b1, 25,  4'b0100, 4'b0000, 1'b1, 1'b0, 1'b1});
    vecQ.push_back('{2'd1, 1'b1, 25,  4'b0010, 4'b0000, 1'b1, 1'b0, 1'b1});
    vecQ.push_back('{2'd1, 1'b1, 25,  4'b0001, 4'b0000, 1'b1, 1'b0, 1'b1});
    vecQ.push_back('{2'd1, 1'b1, 25,  4'b0000, 4'b0001, 1'b0, 1'b1, 1'b1});
    vecQ.push_back('{2'd1, 1'b1, 10,  4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0});
    // freeze for 100 cycles with the count at 10, then resume
    vecQ.push_back('{2'd1, 1'b0, 100, 4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0});
    vecQ.push_back('{2'd1, 1'b1, 14,  4'b0000, 4'b0001, 1'b0, 1'b1, 1'b0});
    vecQ.push_back('{2'd1, 1'b1, 1,   4'b0000, 4'b0010, 1'b0, 1'b1, 1'b1});
    vecQ.push_back('{2'd1, 1'b1, 25,  4'b0000, 4'b0100, 1'b0, 1'b1, 1'b1});
    vecQ.push_back('{2'd1, 1'b1, 25,  4'b0000, 4'b1000, 1'b0, 1'b1, 1'b1});
    vecQ.push_back('{2'd1, 1'b1, 25,  4'b1000, 4'b0000, 1'b1, 1'b0, 1'b1});
    // CHASE then switch to BLINK with the count at 10
    vecQ.push_back('{2'd0, 1'b1, 1,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd0, 1'b1, 25,  4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1});
    vecQ.push_back('{2'd0, 1'b1, 10,  4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd2, 1'b1, 1,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd2, 1'b1, 24,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd2, 1'b1, 1,   4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1});
    vecQ.push_back('{2'd2, 1'b1, 25,  4'b0000, 4'b1111, 1'b0, 1'b0, 1'b1});
    vecQ.push_back('{2'd2, 1'b1, 25,  4'b1111, 4'b0000, 1'b0, 1'b0, 1'b1});
    // OFF: lamps dark, tick still pulses
    vecQ.push_back('{2'd3, 1'b1, 1,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd3, 1'b1, 24,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b0});
    vecQ.push_back('{2'd3, 1'b1, 1,   4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1});
    vecQ.push_back('{2'd3, 1'b1, 25,  4'b0000, 4'b0000, 1'b0, 1'b0, 1'b1});

    #3;
    checkOutput("reset dut0", {red0, green0, rTask0, gTask0, tick0}, 11'd0);
    checkOutput("reset dut2", {red2, green2, rTask2, gTask2, tick2}, 11'd0);
    #19;
    rst = 1'b0;

    foreach (vecQ[i]) begin
      applyStimulus(vecQ[i].mode, vecQ[i].en, vecQ[i].cycles);
      checkOutput($sformatf("vec%0d", i), {red0, green0, rTask0, gTask0, tick0},
                  packExp(vecQ[i].expRed, vecQ[i].expGreen, vecQ[i].expRTask,
                          vecQ[i].expGTask, vecQ[i].expTick));
    end

    // Async reset mid-pattern clears outputs without waiting for an edge.
    applyStimulus(2'd0, 1'b1, 26);
    checkOutput("chase before rst", {red0, green0, rTask0, gTask0, tick0},
                packExp(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1));
    applyStimulus(2'd0, 1'b1, 5);
    rst = 1'b1;
    #2;
    checkOutput("async rst clear", {red0, green0, rTask0, gTask0, tick0}, 11'd0);
    #1;
    rst = 1'b0;
    applyStimulus(2'd0, 1'b1, 24);
    checkOutput("post rst no step", {red0, green0, rTask0, gTask0, tick0}, 11'd0);
    applyStimulus(2'd0, 1'b1, 1);
    checkOutput("post rst first step", {red0, green0, rTask0, gTask0, tick0},
                packExp(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b1));
    checkOutput("ofs2 step0", {red1, green1, rTask1, gTask1, tick1},
                packExp(4'b0001, 4'b0100, 1'b0, 1'b0, 1'b1));
    applyStimulus(2'd0, 1'b1, 25);
    checkOutput("ofs2 step1", {red1, green1, rTask1, gTask1, tick1},
                packExp(4'b0010, 4'b1000, 1'b0, 1'b0, 1'b1));

    // TICK_DIV=1 steps on every enabled edge.
    en2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      stepClk(1);
      checkOutput($sformatf("div1 step%0d", k), {red2, green2, rTask2, gTask2, tick2},
                  packExp(seq2[k], seq2[k], 1'b0, 1'b0, 1'b1));
    end
    en2 = 1'b0;
    stepClk(1);
    checkOutput("div1 frozen", {red2, green2, rTask2, gTask2, tick2},
                packExp(4'b0001, 4'b0001, 1'b0, 1'b0, 1'b0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
